// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared definitions for the Wishbone master arbiter
// Purpose: FSM state encoding, port-count limit and width helpers.
// Ports:   none (package).
package wb_arb_pkg;

   localparam int MAX_PORTS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TOERR = 2'd2
   } arb_state_e;

   // Watchdog width; a disabled watchdog still gets one bit so the
   // register declaration stays legal.
   function automatic int wd_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/wb_arb_rr_sel.sv
// rtl/wb_arb_rr_sel.sv - rotating-mask priority encoder for the arbiter
// Purpose: pick one requester, searching from start_i (round robin) or
//          from index 0 (fixed priority).
// Ports:   req_i   requests, one bit per master
//          start_i first index searched when ROUND_ROBIN != 0
//          gnt_o   one-hot winner (0 when nobody requests)
//          idx_o   binary index of the winner
module wb_arb_rr_sel #(
   parameter int PORTS       = 2,
   parameter int IDXW        = 1,
   parameter int ROUND_ROBIN = 1
) (
   input  logic [PORTS-1:0] req_i,
   input  logic [IDXW-1:0]  start_i,
   output logic [PORTS-1:0] gnt_o,
   output logic [IDXW-1:0]  idx_o
);

   localparam logic [IDXW:0] PORTS_W = PORTS[IDXW:0];

   logic [IDXW:0] pos;
   logic          found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      pos   = '0;
      for (int i = 0; i < PORTS; i++) begin
         // One spare bit holds start+i before the wrap back into range.
         pos = ((ROUND_ROBIN != 0) ? {1'b0, start_i} : '0) + i[IDXW:0];
         if (pos >= PORTS_W) pos = pos - PORTS_W;
         if (!found && req_i[pos[IDXW-1:0]]) begin
            found                  = 1'b1;
            gnt_o[pos[IDXW-1:0]]   = 1'b1;
            idx_o                  = pos[IDXW-1:0];
         end
      end
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// rtl/wb_master_arbiter.sv - shares one Wishbone slave among several masters
// Purpose: round-robin / fixed-priority arbiter holding the grant for the
//          owner's whole cyc, with a watchdog that errors out stalled strobes.
// Ports:   m_*_i / m_*_o  packed master-side buses, port k at slice k
//          wb_*_o / wb_*_i slave-side bus
//          grant, grant_valid  current owner (status)
//          timeout_event       one-cycle pulse while the forced error is sent
module wb_master_arbiter #(
   parameter int PORTS           = 2,
   parameter int WB_DATA_WIDTH   = 32,
   parameter int WB_ADDR_WIDTH   = 32,
   parameter int WB_SELECT_WIDTH = WB_DATA_WIDTH / 8,
   parameter int ROUND_ROBIN     = 1,
   parameter int TIMEOUT         = 256
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [PORTS*WB_ADDR_WIDTH-1:0]     m_adr_i,
   input  logic [PORTS*WB_DATA_WIDTH-1:0]     m_dat_i,
   output logic [WB_DATA_WIDTH-1:0]           m_dat_o,
   input  logic [PORTS-1:0]                   m_we_i,
   input  logic [PORTS*WB_SELECT_WIDTH-1:0]   m_sel_i,
   input  logic [PORTS-1:0]                   m_stb_i,
   input  logic [PORTS-1:0]                   m_cyc_i,
   output logic [PORTS-1:0]                   m_ack_o,
   output logic [PORTS-1:0]                   m_err_o,
   output logic [WB_ADDR_WIDTH-1:0]           wb_adr_o,
   input  logic [WB_DATA_WIDTH-1:0]           wb_dat_i,
   output logic [WB_DATA_WIDTH-1:0]           wb_dat_o,
   output logic                               wb_we_o,
   output logic [WB_SELECT_WIDTH-1:0]         wb_sel_o,
   output logic                               wb_stb_o,
   input  logic                               wb_ack_i,
   input  logic                               wb_err_i,
   output logic                               wb_cyc_o,
   output logic [PORTS-1:0]                   grant,
   output logic                               grant_valid,
   output logic                               timeout_event
);

   import wb_arb_pkg::*;

   localparam int IDXW = $clog2(PORTS);
   localparam int WDW  = wd_width(TIMEOUT);
   localparam int PM1  = PORTS - 1;
   localparam logic [IDXW-1:0] LAST_IDX = PM1[IDXW-1:0];
   localparam logic [WDW-1:0]  TO_W     = TIMEOUT[WDW-1:0];

   arb_state_e       state_q;
   logic [PORTS-1:0] grant_q;
   logic [IDXW-1:0]  gidx_q;
   logic [IDXW-1:0]  rr_ptr_q;
   logic [WDW-1:0]   wd_q;
   logic             tev_q;

   logic [PORTS-1:0] sel_gnt;
   logic [IDXW-1:0]  sel_idx;
   logic [IDXW-1:0]  ptr_d;
   logic [WDW-1:0]   wd_d;
   logic             cyc_g;
   logic             stb_g;

   wb_arb_rr_sel #(
      .PORTS       (PORTS),
      .IDXW        (IDXW),
      .ROUND_ROBIN (ROUND_ROBIN)
   ) u_sel (
      .req_i   (m_cyc_i),
      .start_i (rr_ptr_q),
      .gnt_o   (sel_gnt),
      .idx_o   (sel_idx)
   );

   assign cyc_g = m_cyc_i[gidx_q];
   assign stb_g = m_stb_i[gidx_q] & cyc_g;
   assign ptr_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
   assign wd_d  = wd_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         rr_ptr_q <= '0;
         wd_q     <= '0;
         tev_q    <= 1'b0;
      end else begin
         tev_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|m_cyc_i) begin
                  state_q <= ST_GRANT;
                  grant_q <= sel_gnt;
                  gidx_q  <= sel_idx;
                  wd_q    <= '0;
               end
            end
            ST_GRANT: begin
               if (!cyc_g) begin
                  state_q  <= ST_IDLE;
                  grant_q  <= '0;
                  rr_ptr_q <= ptr_d;
                  wd_q     <= '0;
               end else if (wb_ack_i || wb_err_i) begin
                  // A response in the expiry cycle beats the watchdog.
                  wd_q <= '0;
               end else if (stb_g && (TIMEOUT != 0)) begin
                  if (wd_d == TO_W) begin
                     state_q <= ST_TOERR;
                     tev_q   <= 1'b1;
                  end
                  wd_q <= wd_d;
               end
            end
            ST_TOERR: begin
               wd_q <= '0;
               if (cyc_g) begin
                  state_q <= ST_GRANT;
               end else begin
                  state_q  <= ST_IDLE;
                  grant_q  <= '0;
                  rr_ptr_q <= ptr_d;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   // Address/data/select follow the owner unconditionally; only the
   // handshake signals are gated by state.
   always_comb begin
      wb_adr_o = '0;
      wb_dat_o = '0;
      wb_we_o  = 1'b0;
      wb_sel_o = '0;
      for (int k = 0; k < PORTS; k++) begin
         if (gidx_q == k[IDXW-1:0]) begin
            wb_adr_o = m_adr_i[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
            wb_dat_o = m_dat_i[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
            wb_we_o  = m_we_i[k];
            wb_sel_o = m_sel_i[k*WB_SELECT_WIDTH +: WB_SELECT_WIDTH];
         end
      end
   end

   always_comb begin
      wb_cyc_o = 1'b0;
      wb_stb_o = 1'b0;
      m_ack_o  = '0;
      m_err_o  = '0;
      case (state_q)
         ST_GRANT: begin
            wb_cyc_o        = cyc_g;
            wb_stb_o        = stb_g;
            m_ack_o[gidx_q] = wb_ack_i;
            m_err_o[gidx_q] = wb_err_i;
         end
         ST_TOERR: begin
            // Slave responses this cycle belong to the abandoned strobe.
            wb_cyc_o        = cyc_g;
            m_err_o[gidx_q] = 1'b1;
         end
         default: ;
      endcase
   end

   assign m_dat_o       = wb_dat_i;
   assign grant         = grant_q;
   assign grant_valid   = |grant_q;
   assign timeout_event = tev_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb/tb_wb_master_arbiter.sv - directed self-checking bench for wb_master_arbiter
module tb_wb_master_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] m_adr;
   logic [63:0] m_dat;
   logic [1:0]  m_we;
   logic [7:0]  m_sel;
   logic [1:0]  m_stb;
   logic [1:0]  m_cyc;
   logic [31:0] wb_dat_in;
   logic        wb_ack;
   logic        wb_err;

   logic [31:0] m_dat_o,   m_dat_o_f;
   logic [1:0]  m_ack_o,   m_ack_o_f;
   logic [1:0]  m_err_o,   m_err_o_f;
   logic [31:0] wb_adr_o,  wb_adr_o_f;
   logic [31:0] wb_dat_o,  wb_dat_o_f;
   logic        wb_we_o,   wb_we_o_f;
   logic [3:0]  wb_sel_o,  wb_sel_o_f;
   logic        wb_stb_o,  wb_stb_o_f;
   logic        wb_cyc_o,  wb_cyc_o_f;
   logic [1:0]  grant,     grant_f;
   logic        grant_valid, grant_valid_f;
   logic        tev,       tev_f;

   int n_assert = 0;
   int n_fail   = 0;
   logic [1:0] e1h;

   always #5 clk = ~clk;

   wb_master_arbiter #(.PORTS(2), .ROUND_ROBIN(1), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
      .m_we_i(m_we), .m_sel_i(m_sel), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_in), .wb_dat_o(wb_dat_o),
      .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
      .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_cyc_o(wb_cyc_o),
      .grant(grant), .grant_valid(grant_valid), .timeout_event(tev)
   );

   wb_master_arbiter #(.PORTS(2), .ROUND_ROBIN(0), .TIMEOUT(8)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o_f),
      .m_we_i(m_we), .m_sel_i(m_sel), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
      .m_ack_o(m_ack_o_f), .m_err_o(m_err_o_f),
      .wb_adr_o(wb_adr_o_f), .wb_dat_i(wb_dat_in), .wb_dat_o(wb_dat_o_f),
      .wb_we_o(wb_we_o_f), .wb_sel_o(wb_sel_o_f), .wb_stb_o(wb_stb_o_f),
      .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_cyc_o(wb_cyc_o_f),
      .grant(grant_f), .grant_valid(grant_valid_f), .timeout_event(tev_f)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; m_adr = '0; m_dat = '0; m_we = '0; m_sel = '0;
      m_stb = '0; m_cyc = '0; wb_dat_in = '0; wb_ack = 1'b0; wb_err = 1'b0;
      tick();
      chk("rst_wb_cyc", wb_cyc_o, 0);
      chk("rst_wb_stb", wb_stb_o, 0);
      chk("rst_grant", grant, 0);
      chk("rst_grant_valid", grant_valid, 0);
      chk("rst_ack", m_ack_o, 0);
      chk("rst_err", m_err_o, 0);
      chk("rst_tev", tev, 0);
      rst_n = 1'b1;
      tick();

      // Round robin: both masters keep requesting, owner alternates 0,1,0,1.
      m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
      tick();
      for (int r = 0; r < 4; r++) begin
         e1h = (r % 2 == 0) ? 2'b01 : 2'b10;
         chk("rr_grant", grant, e1h);
         wb_dat_in = 32'hA000_0000 + r;
         wb_ack = 1'b1;
         #1;
         chk("rr_ack_only_owner", m_ack_o, e1h);
         chk("rr_rdata", m_dat_o, 32'hA000_0000 + r);
         tick();
         wb_ack = 1'b0;
         m_cyc = m_cyc & ~e1h;
         m_stb = m_stb & ~e1h;
         #1;
         chk("rr_release_cyc", wb_cyc_o, 0);
         tick();
         chk("rr_idle_gap", grant, 0);
         m_cyc = 2'b11; m_stb = 2'b11;
         tick();
      end
      m_cyc = '0; m_stb = '0;
      tick(); tick();

      // Single master write on port 0, slave acks after 2 cycles.
      m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_sel = 8'h0F;
      m_adr = {32'h0, 32'h0000_0010}; m_dat = {32'h0, 32'hDEAD_BEEF};
      #1;
      chk("w_latency_cyc0", wb_cyc_o, 0);
      tick();
      chk("w_wb_cyc", wb_cyc_o, 1);
      chk("w_grant", grant, 2'b01);
      chk("w_grant_valid", grant_valid, 1);
      chk("w_adr", wb_adr_o, 32'h10);
      chk("w_dat", wb_dat_o, 32'hDEAD_BEEF);
      chk("w_we", wb_we_o, 1);
      chk("w_sel", wb_sel_o, 4'hF);
      chk("w_stb", wb_stb_o, 1);
      chk("w_no_ack_yet", m_ack_o, 0);
      tick(); tick();
      wb_ack = 1'b1;
      #1;
      chk("w_ack", m_ack_o, 2'b01);
      tick();
      wb_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
      tick(); tick();
      chk("w_idle_grant", grant, 0);
      chk("w_idle_valid", grant_valid, 0);

      // Fixed priority starvation, compared against round robin.
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      m_cyc = 2'b11; m_stb = 2'b11;
      tick();
      chk("fp_first_grant", grant_f, 2'b01);
      wb_ack = 1'b1;
      #1;
      chk("fp_ack", m_ack_o_f, 2'b01);
      tick();
      wb_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10;
      tick();
      chk("fp_idle", grant_f, 0);
      m_cyc = 2'b11; m_stb = 2'b11;
      tick();
      chk("fp_port1_starved", grant_f, 2'b01);
      chk("rr_port1_served", grant, 2'b10);
      m_cyc = 2'b10; m_stb = 2'b10;
      tick();
      chk("fp_release_idle", grant_f, 0);
      tick();
      chk("fp_port1_granted", grant_f, 2'b10);
      m_cyc = '0; m_stb = '0;
      tick(); tick();

      // Watchdog expiry with a late ack in the error cycle.
      m_cyc = 2'b01; m_stb = 2'b01;
      tick();
      for (int i = 0; i < 7; i++) tick();
      chk("to_stb_before", wb_stb_o, 1);
      chk("to_err_before", m_err_o, 0);
      chk("to_tev_before", tev, 0);
      tick();
      wb_ack = 1'b1;
      #1;
      chk("to_err", m_err_o, 2'b01);
      chk("to_late_ack_dropped", m_ack_o, 0);
      chk("to_tev", tev, 1);
      chk("to_stb_forced", wb_stb_o, 0);
      chk("to_cyc_held", wb_cyc_o, 1);
      tick();
      wb_ack = 1'b0; m_stb = 2'b00;
      #1;
      chk("to_tev_pulse", tev, 0);
      chk("to_err_pulse", m_err_o, 0);
      m_cyc = '0;
      tick(); tick();

      // Ack in the expiry cycle wins over the watchdog.
      m_cyc = 2'b01; m_stb = 2'b01;
      tick();
      for (int i = 0; i < 7; i++) tick();
      wb_ack = 1'b1;
      #1;
      chk("race_ack", m_ack_o, 2'b01);
      chk("race_no_err", m_err_o, 0);
      tick();
      wb_ack = 1'b0;
      #1;
      chk("race_no_tev", tev, 0);
      chk("race_no_err_after", m_err_o, 0);
      chk("race_still_granted", wb_stb_o, 1);
      m_cyc = '0; m_stb = '0;
      tick(); tick();

      // Asynchronous reset while port 1 owns the bus.
      m_cyc = 2'b10; m_stb = 2'b10;
      tick();
      chk("rst_mid_grant", grant, 2'b10);
      wb_ack = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_cyc", wb_cyc_o, 0);
      chk("rst_mid_stb", wb_stb_o, 0);
      chk("rst_mid_ack", m_ack_o, 0);
      chk("rst_mid_grant0", grant, 0);
      chk("rst_mid_valid", grant_valid, 0);
      m_cyc = 2'b11; m_stb = 2'b11;
      tick();
      rst_n = 1'b1; wb_ack = 1'b0;
      tick();
      chk("rst_after_port0", grant, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
